// File: rtl/coproc_sched_pkg.sv
// Shared types for the coprocessor command scheduler: command word layout and FSM states.
package coproc_sched_pkg;

  localparam int FUNC_W = 3;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic              gray;
    logic              img_idx;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sched_cmd_fifo.sv
// First-word-fall-through command FIFO with push, pop, flush and occupancy count.
module sched_cmd_fifo
  import coproc_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  cmd_t                   wdata,
  output cmd_t                   head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  cmd_t          mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == CW'(0));
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  // flush drops a same-cycle push; a same-cycle pop has already read head
  assign push_ok_s = push & ~full & ~flush;
  assign pop_ok_s  = pop & ~empty;

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/coproc_cmd_sched.sv
// Issues queued commands to the image coprocessor one at a time with completion tracking.
// Optional WAIT_DONE watchdog enabled by defining COPROC_SCHED_TIMEOUT_EN.
module coproc_cmd_sched
  import coproc_sched_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [FUNC_W-1:0]      cmd_func,
  input  logic                   cmd_gray,
  input  logic                   cmd_img_idx,
  input  logic                   flush,
  input  logic                   irq_en,
  input  logic                   irq_clr,
  input  logic                   cp_rdy,
  input  logic                   cp_done,
  output logic                   cp_start,
  output logic [FUNC_W-1:0]      cp_func,
  output logic                   cp_gray,
  output logic                   cp_img_idx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic [CNT_W-1:0]       done_cnt,
  output logic                   irq,
  output logic                   err_spur,
  output logic                   timeout
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t  state_r;
  cmd_t    cmd_in_s;
  cmd_t    head_s;
  logic    fifo_full_s;
  logic    fifo_empty_s;
  logic    pop_s;
  logic    wd_hit_s;
  logic    irq_set_s;
  logic    spur_set_s;
  logic    to_set_s;

  assign cmd_in_s  = '{func: cmd_func, gray: cmd_gray, img_idx: cmd_img_idx};
  assign cmd_ready = ~fifo_full_s;
  assign busy      = (state_r != IDLE) | (fifo_cnt != CW'(0));

  sched_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid),
    .pop   (pop_s),
    .flush (flush),
    .wdata (cmd_in_s),
    .head  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_cnt)
  );

`ifdef COPROC_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] wd_cnt_r;

  // Counts consecutive WAIT_DONE cycles; cleared everywhere else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_r <= '0;
    end else if ((state_r == WAIT_DONE) && !cp_done) begin
      wd_cnt_r <= wd_cnt_r + TW'(1);
    end else begin
      wd_cnt_r <= '0;
    end
  end

  assign wd_hit_s = (state_r == WAIT_DONE) && (wd_cnt_r == TW'(TIMEOUT_CYCLES - 1));
`else
  assign wd_hit_s = 1'b0;
`endif

  // Pop decision and sticky-flag set conditions
  always_comb begin
    pop_s      = 1'b0;
    irq_set_s  = 1'b0;
    spur_set_s = 1'b0;
    to_set_s   = 1'b0;
    if ((state_r == IDLE) && !fifo_empty_s && cp_rdy) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    if (state_r == WAIT_DONE) begin
      irq_set_s = cp_done & irq_en;
      to_set_s  = wd_hit_s & ~cp_done;
    end else begin
      spur_set_s = cp_done;
    end
  end

  // Issue FSM with registered coprocessor interface and completion counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cp_start   <= 1'b0;
      cp_func    <= '0;
      cp_gray    <= 1'b0;
      cp_img_idx <= 1'b0;
      done_cnt   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            state_r    <= START;
            cp_start   <= 1'b1;
            cp_func    <= head_s.func;
            cp_gray    <= head_s.gray;
            cp_img_idx <= head_s.img_idx;
          end else begin
            state_r  <= IDLE;
            cp_start <= 1'b0;
          end
        end
        START: begin
          state_r  <= WAIT_DONE;
          cp_start <= 1'b0;
        end
        WAIT_DONE: begin
          cp_start <= 1'b0;
          if (cp_done) begin
            state_r  <= IDLE;
            done_cnt <= done_cnt + CNT_W'(1);
          end else if (wd_hit_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= WAIT_DONE;
          end
        end
        default: begin
          state_r  <= IDLE;
          cp_start <= 1'b0;
        end
      endcase
    end
  end

  // Sticky status flags; a set in the same cycle as irq_clr takes priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq      <= 1'b0;
      err_spur <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      irq      <= irq_set_s  | (irq      & ~irq_clr);
      err_spur <= spur_set_s | (err_spur & ~irq_clr);
      timeout  <= to_set_s   | (timeout  & ~irq_clr);
    end
  end

endmodule

// File: tb/tb_coproc_cmd_sched.sv
// Scoreboard bench for coproc_cmd_sched: issue order checked by a cp_start monitor, status by directed checks.
module tb_coproc_cmd_sched;
  import coproc_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, cmd_valid, cmd_ready, cmd_gray, cmd_img_idx, flush, irq_en, irq_clr;
  logic       cp_rdy, cp_done, cp_start, cp_gray, cp_img_idx, busy, irq, err_spur, timeout;
  logic [2:0] cmd_func, cp_func;
  logic [2:0] fifo_cnt;
  logic [15:0] done_cnt;

  int   total = 0;
  int   bad   = 0;
  cmd_t exp_q[$];
  logic prev_start = 1'b0;

  always #5 clk = ~clk;

  coproc_cmd_sched #(.DEPTH(4), .CNT_W(16), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_func(cmd_func), .cmd_gray(cmd_gray), .cmd_img_idx(cmd_img_idx),
    .flush(flush), .irq_en(irq_en), .irq_clr(irq_clr), .cp_rdy(cp_rdy), .cp_done(cp_done),
    .cp_start(cp_start), .cp_func(cp_func), .cp_gray(cp_gray), .cp_img_idx(cp_img_idx),
    .busy(busy), .fifo_cnt(fifo_cnt), .done_cnt(done_cnt), .irq(irq),
    .err_spur(err_spur), .timeout(timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] f, input logic g, input logic i, input bit issues);
    cmd_t c;
    c = '{func: f, gray: g, img_idx: i};
    if (issues) exp_q.push_back(c);
    cmd_valid = 1'b1; cmd_func = f; cmd_gray = g; cmd_img_idx = i;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    int n = 0;
    while (!cp_start && n < 40) begin
      tick();
      n++;
    end
    ok = cp_start;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL start_wait actual=no_start expected=cp_start within 40 cycles");
    end
  endtask

  task automatic run_cmd();
    bit ok;
    wait_start(ok);
    if (ok) begin
      tick();
      cp_done = 1'b1;
      tick();
      cp_done = 1'b0;
    end
  endtask

  // Monitor: every start pulse must match the next expected command and last one cycle
  always @(negedge clk) begin
    cmd_t e;
    if (!rst_n) begin
      prev_start = 1'b0;
    end else begin
      if (cp_start) begin
        total++;
        if (prev_start) begin
          bad++;
          $display("FAIL start_width actual=2+ cycles expected=1 cycle at %0t", $time);
        end else if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL start_unexpected actual=func %0d expected=no start at %0t", cp_func, $time);
        end else begin
          e = exp_q.pop_front();
          if ({cp_func, cp_gray, cp_img_idx} !== e) begin
            bad++;
            $display("FAIL start_cmd actual=%0h expected=%0h at %0t",
                     {cp_func, cp_gray, cp_img_idx}, e, $time);
          end
        end
      end
      prev_start = cp_start;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    bit ok;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_func = 3'd0; cmd_gray = 1'b0; cmd_img_idx = 1'b0;
    flush = 1'b0; irq_en = 1'b1; irq_clr = 1'b0; cp_rdy = 1'b1; cp_done = 1'b0;
    tick(); tick();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_outs", {cp_start, cp_func, cp_gray, cp_img_idx, busy, irq, err_spur, timeout}, 0);
    chk("rst_cnts", {fifo_cnt, done_cnt}, 0);
    rst_n = 1'b1;
    tick();

    // 1: single command latency, hold, completion
    push(3'd3, 1'b1, 1'b0, 1'b1);
    chk("t1_n1_start", cp_start, 0);
    chk("t1_n1_cnt", fifo_cnt, 1);
    tick();
    chk("t1_n2_start", cp_start, 1);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_pulse_end", cp_start, 0);
    tick(); tick();
    chk("t1_hold", {cp_func, cp_gray, cp_img_idx}, {3'd3, 1'b1, 1'b0});
    cp_done = 1'b1;
    tick();
    cp_done = 1'b0;
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_irq", irq, 1);
    chk("t1_idle", busy, 0);
    chk("t1_keep", cp_func, 3);

    // 2: fill to full with coprocessor not ready, then drain in order
    cp_rdy = 1'b0;
    push(3'd1, 1'b0, 1'b1, 1'b1);
    push(3'd2, 1'b1, 1'b1, 1'b1);
    push(3'd4, 1'b0, 1'b0, 1'b1);
    push(3'd7, 1'b1, 1'b0, 1'b1);
    chk("t2_full_cnt", fifo_cnt, 4);
    chk("t2_full_ready", cmd_ready, 0);
    push(3'd6, 1'b1, 1'b1, 1'b0);
    chk("t2_no_overflow", fifo_cnt, 4);
    cp_rdy = 1'b1;
    for (int k = 0; k < 4; k++) run_cmd();
    chk("t2_done_cnt", done_cnt, 5);
    chk("t2_drained", {busy, fifo_cnt}, 0);

    // 3: simultaneous push/pop, then flush with one in flight
    cp_rdy = 1'b0;
    push(3'd5, 1'b1, 1'b0, 1'b1);
    push(3'd2, 1'b0, 1'b0, 1'b0);
    cmd_valid = 1'b1; cmd_func = 3'd1; cmd_gray = 1'b1; cmd_img_idx = 1'b1; cp_rdy = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("t3_pushpop_cnt", fifo_cnt, 2);
    chk("t3_pushpop_start", cp_start, 1);
    push(3'd0, 1'b0, 1'b1, 1'b0);
    chk("t3_three_queued", fifo_cnt, 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t3_flushed", fifo_cnt, 0);
    chk("t3_busy_inflight", busy, 1);
    cp_done = 1'b1;
    tick();
    cp_done = 1'b0;
    chk("t3_done_cnt", done_cnt, 6);
    chk("t3_busy_after", busy, 0);
    repeat (4) tick();
    cp_rdy = 1'b0; cmd_valid = 1'b1; flush = 1'b1;
    tick();
    cmd_valid = 1'b0; flush = 1'b0; cp_rdy = 1'b1;
    chk("t3_flush_beats_push", fifo_cnt, 0);

    // 4: spurious done, irq clear, clear colliding with set
    cp_done = 1'b1;
    tick();
    cp_done = 1'b0;
    chk("t4_spur", err_spur, 1);
    chk("t4_spur_cnt", done_cnt, 6);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    chk("t4_clr", {irq, err_spur}, 0);
    push(3'd5, 1'b0, 1'b1, 1'b1);
    wait_start(ok);
    tick();
    cp_done = 1'b1; irq_clr = 1'b1;
    tick();
    cp_done = 1'b0; irq_clr = 1'b0;
    chk("t4_set_wins", irq, 1);
    chk("t4_done_cnt", done_cnt, 7);

    // 5: reset during WAIT_DONE with two queued
    push(3'd6, 1'b1, 1'b1, 1'b1);
    wait_start(ok);
    tick();
    push(3'd7, 1'b0, 1'b0, 1'b0);
    push(3'd0, 1'b1, 1'b0, 1'b0);
    chk("t5_queued", fifo_cnt, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", cmd_ready, 1);
    chk("t5_rst_outs", {cp_start, cp_func, cp_gray, cp_img_idx, busy, irq, err_spur, timeout}, 0);
    chk("t5_rst_cnts", {fifo_cnt, done_cnt}, 0);
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("t5_quiet", {busy, fifo_cnt}, 0);

`ifdef COPROC_SCHED_TIMEOUT_EN
    // 6: watchdog expiry, next queued command still issues
    push(3'd1, 1'b1, 1'b1, 1'b1);
    push(3'd2, 1'b0, 1'b0, 1'b1);
    wait_start(ok);
    repeat (16) tick();
    chk("t6_before_to", timeout, 0);
    tick();
    chk("t6_timeout", timeout, 1);
    chk("t6_no_count", done_cnt, 0);
    run_cmd();
    chk("t6_next_done", done_cnt, 1);
`else
    // 6: without the watchdog a missing done waits indefinitely
    push(3'd1, 1'b1, 1'b1, 1'b1);
    wait_start(ok);
    repeat (40) tick();
    chk("t6_no_timeout", {busy, timeout}, {1'b1, 1'b0});
    cp_done = 1'b1;
    tick();
    cp_done = 1'b0;
    chk("t6_late_done", done_cnt, 1);
`endif

    repeat (3) tick();
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
